// File: rtl/take_in_pkg.sv
// Shared types and sizing helpers for the take_in_multi packet receiver.
package take_in_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_COLLECT  = 2'd2,
        ST_DISPATCH = 2'd3
    } state_t;

    // Each buffer entry carries its payload plus a valid flag in the LSB.
    function automatic int entry_w(input int payload_w);
        return payload_w + 1;
    endfunction

    // Occupancy counters must be able to represent "completely full".
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/take_in_multi_chan_fifo.sv
// One channel shift buffer: slot 0 is the oldest entry, new entries append
// at the current occupancy, and pops shift every slot down by one.
module chan_fifo
    import take_in_pkg::*;
#(
    parameter int DEPTH       = 6,
    parameter int PAYLOAD_W   = 2,
    parameter int DROP_NEWEST = 0,
    localparam int EW         = entry_w(PAYLOAD_W),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [PAYLOAD_W-1:0]   push_data,
    input  logic                   pop,
    output logic [DEPTH*EW-1:0]    entries,
    output logic [CNT_W-1:0]       occ,
    output logic [PAYLOAD_W-1:0]   head,
    output logic                   dropped
);

    logic [PAYLOAD_W-1:0] data_reg  [DEPTH];
    logic [PAYLOAD_W-1:0] data_next [DEPTH];
    logic [CNT_W-1:0]     occ_reg;
    logic [CNT_W-1:0]     occ_next;
    logic                 do_pop;
    logic                 full;

    assign do_pop = pop && (occ_reg != '0);
    assign full   = (occ_reg == CNT_W'(DEPTH));

    // Next buffer image: pop shifts first, then the push lands behind it.
    // A simultaneous pop frees a slot, so a push never drops in that case.
    always_comb begin
        data_next = data_reg;
        occ_next  = occ_reg;
        dropped   = 1'b0;
        if (do_pop) begin
            for (int s = 0; s < DEPTH - 1; s++) begin
                data_next[s] = data_reg[s+1];
            end
            data_next[DEPTH-1] = '0;
            occ_next = occ_reg - CNT_W'(1);
        end
        if (push) begin
            if (!do_pop && full) begin
                dropped = 1'b1;
                if (DROP_NEWEST == 0) begin
                    for (int s = 0; s < DEPTH - 1; s++) begin
                        data_next[s] = data_reg[s+1];
                    end
                    data_next[DEPTH-1] = push_data;
                end
            end else begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (CNT_W'(s) == occ_next) begin
                        data_next[s] = push_data;
                    end
                end
                occ_next = occ_next + CNT_W'(1);
            end
        end
    end

    // Buffer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_reg[s] <= '0;
            end
            occ_reg <= '0;
        end else begin
            data_reg <= data_next;
            occ_reg  <= occ_next;
        end
    end

    // Valid flag is derived from occupancy; vacated slots hold zero data.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign entries[gi*EW +: EW] = {data_reg[gi], (CNT_W'(gi) < occ_reg)};
        end
    endgenerate

    assign occ  = occ_reg;
    assign head = data_reg[0];

endmodule

// File: rtl/take_in_multi.sv
// Two-button serial packet receiver: assembles MSB-first packets from key
// presses and routes the payload into one of NUM_CH shift buffers.
module take_in_multi
    import take_in_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PAYLOAD_W   = 2,
    parameter int DEPTH       = 6,
    parameter int DROP_NEWEST = 0,
    parameter int START_DLY   = 3,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int PKT_W      = CH_W + PAYLOAD_W,
    localparam int EW         = entry_w(PAYLOAD_W),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          key0,
    input  logic                          key1,
    input  logic                          rd_en,
    input  logic [CH_W-1:0]               rd_ch,
    output logic [PAYLOAD_W-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [NUM_CH*DEPTH*EW-1:0]    buf_flat,
    output logic [NUM_CH*CNT_W-1:0]       occ_flat,
    output logic [PKT_W-1:0]              last_pkt,
    output logic [15:0]                   drop_cnt,
    output logic [15:0]                   rx_cnt
);

    localparam int IDX_W = $clog2(PKT_W);
    localparam int DLY_W = $clog2(START_DLY + 1);

    state_t               state_reg;
    logic                 key0_q;
    logic                 key1_q;
    logic [IDX_W-1:0]     idx_reg;
    logic [DLY_W-1:0]     arm_cnt_reg;
    logic [PKT_W-1:0]     shift_reg;
    logic [PKT_W-1:0]     pkt_next;
    logic [PKT_W-1:0]     last_pkt_reg;
    logic                 press0;
    logic                 press1;
    logic                 press;
    logic [CH_W-1:0]      push_ch;
    logic [CNT_W-1:0]     occ_arr  [NUM_CH];
    logic [PAYLOAD_W-1:0] head_arr [NUM_CH];
    logic [NUM_CH-1:0]    dropped_vec;

    // A press is a falling edge on one key while the other key stays released.
    assign press0 = key0_q & ~key0 & key1;
    assign press1 = key1_q & ~key1 & key0;
    assign press  = press0 | press1;

    // Packet under assembly with the incoming bit placed at its MSB-first slot.
    always_comb begin
        pkt_next = shift_reg;
        pkt_next[PKT_W-1-int'(idx_reg)] = press1;
    end

    // Receiver FSM: arm on start low, collect PKT_W bits, dispatch for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            key0_q       <= 1'b1;
            key1_q       <= 1'b1;
            idx_reg      <= '0;
            arm_cnt_reg  <= '0;
            shift_reg    <= '0;
            last_pkt_reg <= '0;
        end else begin
            key0_q <= key0;
            key1_q <= key1;
            case (state_reg)
                ST_IDLE: begin
                    if (!start) begin
                        state_reg   <= ST_ARM;
                        arm_cnt_reg <= '0;
                    end
                end
                ST_ARM: begin
                    if (start) begin
                        state_reg   <= ST_IDLE;
                        arm_cnt_reg <= '0;
                    end else if (int'(arm_cnt_reg) + 1 >= START_DLY) begin
                        state_reg   <= ST_COLLECT;
                        arm_cnt_reg <= '0;
                    end else begin
                        arm_cnt_reg <= arm_cnt_reg + DLY_W'(1);
                    end
                end
                ST_COLLECT: begin
                    if (press) begin
                        if (idx_reg == IDX_W'(PKT_W - 1)) begin
                            last_pkt_reg <= pkt_next;
                            shift_reg    <= '0;
                            idx_reg      <= '0;
                            state_reg    <= ST_DISPATCH;
                        end else begin
                            shift_reg <= pkt_next;
                            idx_reg   <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                ST_DISPATCH: state_reg <= ST_IDLE;
                default:     state_reg <= ST_IDLE;
            endcase
        end
    end

    // Saturating statistics: accepted bits and overflow events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (state_reg == ST_COLLECT && press && rx_cnt != 16'hFFFF) begin
                rx_cnt <= rx_cnt + 16'd1;
            end
            if ((|dropped_vec) && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Registered pop result; an empty channel yields no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en && (occ_arr[rd_ch] != '0);
            if (rd_en && (occ_arr[rd_ch] != '0)) begin
                rd_data <= head_arr[rd_ch];
            end
        end
    end

    assign push_ch  = last_pkt_reg[PKT_W-1 -: CH_W];
    assign last_pkt = last_pkt_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            chan_fifo #(
                .DEPTH       (DEPTH),
                .PAYLOAD_W   (PAYLOAD_W),
                .DROP_NEWEST (DROP_NEWEST)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      ((state_reg == ST_DISPATCH) && (push_ch == CH_W'(gi))),
                .push_data (last_pkt_reg[PAYLOAD_W-1:0]),
                .pop       (rd_en && (rd_ch == CH_W'(gi))),
                .entries   (buf_flat[gi*DEPTH*EW +: DEPTH*EW]),
                .occ       (occ_arr[gi]),
                .head      (head_arr[gi]),
                .dropped   (dropped_vec[gi])
            );
            assign occ_flat[gi*CNT_W +: CNT_W] = occ_arr[gi];
        end
    endgenerate

endmodule
